wb_lsu_master: RTL and testbench



---
 rtl/wb_lsu_master.sv | 142 ++++++++++++++
 tb/tb_wb_lsu_master.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_lsu_master.sv
// Load/store Wishbone classic master between the MEM stage and the data memory slave.
// Latency: response 3 cycles after accept (1 on a rejected request); req_ready returns one cycle later.
// Backpressure: req_ready is high only in IDLE; requests presented while busy are ignored and must be held.
module wb_lsu_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 7,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [2:0]                req_funct3,
    output logic                      resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      resp_err,
    output logic                      stall_o,
    output logic [MEM_ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    output logic                      wb_we_o,
    output logic                      wb_stb_o,
    output logic                      wb_cyc_o,
    output logic [2:0]                wb_funct3_o,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    input  logic                      wb_ack_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUS, RECOVER} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             legal;
    logic             aligned;
    logic             in_range;
    logic             checks_ok;
    logic             timeout;

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !req_we;
            default:                legal = 1'b0;
        endcase
        aligned = 1'b1;
        case (req_funct3[1:0])
            2'b01:   aligned = !req_addr[0];
            2'b10:   aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign in_range  = ~|req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
    assign checks_ok = legal && aligned && in_range;
    assign accept    = req_valid && req_ready;
    assign timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = checks_ok ? BUS : RECOVER;
            BUS:     if (wb_ack_i || timeout) state_nxt = RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        stall_o   = (req_valid && (state != IDLE)) || (state != IDLE);
    end

    // Registered bus and response outputs; resp_valid defaults low so it pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_we_o     <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_funct3_o <= 3'b000;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (checks_ok) begin
                            cnt         <= '0;
                            wb_cyc_o    <= 1'b1;
                            wb_stb_o    <= 1'b1;
                            wb_adr_o    <= req_addr[MEM_ADDR_WIDTH-1:0];
                            wb_dat_o    <= req_wdata;
                            wb_we_o     <= req_we;
                            wb_funct3_o <= req_funct3;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= wb_we_o ? '0 : wb_dat_i;
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        wb_we_o    <= 1'b0;
                    end else if (timeout) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        wb_we_o    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master with a byte-addressed 128-byte slave that extends loads itself.
module tb_wb_lsu_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_err, stall_o;
    logic [31:0] resp_rdata;
    logic [6:0]  wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
    logic [2:0]  wb_funct3_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_lsu_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_WIDTH(7), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .stall_o(stall_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o), .wb_funct3_o(wb_funct3_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    // Slave: registered ack, combinational extended read data.
    logic [7:0] mem [0:127];
    logic       ack_en;
    logic [7:0] b0, b1, b2, b3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_ack_i <= 1'b0;
        else        wb_ack_i <= ack_en && wb_cyc_o && wb_stb_o;
    end

    always @(posedge clk) begin
        if (ack_en && wb_cyc_o && wb_stb_o && wb_we_o) begin
            mem[wb_adr_o] <= wb_dat_o[7:0];
            if (wb_funct3_o != 3'b000) mem[wb_adr_o + 7'd1] <= wb_dat_o[15:8];
            if (wb_funct3_o == 3'b010) begin
                mem[wb_adr_o + 7'd2] <= wb_dat_o[23:16];
                mem[wb_adr_o + 7'd3] <= wb_dat_o[31:24];
            end
        end
    end

    always_comb begin
        b0 = mem[wb_adr_o];
        b1 = mem[wb_adr_o + 7'd1];
        b2 = mem[wb_adr_o + 7'd2];
        b3 = mem[wb_adr_o + 7'd3];
        wb_dat_i = 32'h0;
        if (wb_cyc_o && wb_stb_o && !wb_we_o) begin
            case (wb_funct3_o)
                3'b000:  wb_dat_i = {{24{b0[7]}}, b0};
                3'b001:  wb_dat_i = {{16{b1[7]}}, b1, b0};
                3'b010:  wb_dat_i = {b3, b2, b1, b0};
                3'b100:  wb_dat_i = {24'h0, b0};
                3'b101:  wb_dat_i = {16'h0, b1, b0};
                default: wb_dat_i = 32'h0;
            endcase
        end
    end

    // Presents a request for one edge; returns at the negedge of cycle 1 after accept.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Walks cycles from cycle 1 until resp_valid (bounded); resp_cyc stays 0 if none arrives.
    task automatic run_to_resp(output int resp_cyc, output int cyc_cnt, output logic [31:0] rdata, output logic err);
        resp_cyc = 0; cyc_cnt = 0; rdata = 32'h0; err = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (wb_cyc_o) cyc_cnt++;
            if (resp_valid) begin
                resp_cyc = k; rdata = resp_rdata; err = resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, resp_valid, resp_err, stall_o} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {wb_cyc_o, wb_stb_o, wb_we_o, resp_valid, resp_err, stall_o}); end
        n_checks++; if ({wb_adr_o, wb_dat_o, resp_rdata, wb_funct3_o} !== 74'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {wb_adr_o, wb_dat_o, resp_rdata, wb_funct3_o}); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_load_nop;
        int rc, cc; logic [31:0] rd; logic er;
        issue(1'b0, 32'h10, 32'h0, 3'b010);
        n_checks++; if ({wb_cyc_o, wb_stb_o, stall_o, req_ready} !== 4'b1110) begin n_fail++; $display("FAIL lw_cycle1: got %b expected 1110", {wb_cyc_o, wb_stb_o, stall_o, req_ready}); end
        run_to_resp(rc, cc, rd, er);
        n_checks++; if (rc !== 3) begin n_fail++; $display("FAIL lw_resp_cycle: got %0d expected 3", rc); end
        n_checks++; if (cc !== 2) begin n_fail++; $display("FAIL lw_cyc_cycles: got %0d expected 2", cc); end
        n_checks++; if (rd !== 32'h00000033 || er !== 1'b0) begin n_fail++; $display("FAIL lw_data: got %h/%b expected 00000033/0", rd, er); end
        @(negedge clk);
        n_checks++; if ({req_ready, resp_valid, wb_cyc_o} !== 3'b100) begin n_fail++; $display("FAIL lw_cycle4: got %b expected 100", {req_ready, resp_valid, wb_cyc_o}); end
    endtask

    task automatic test_store_load;
        int rc, cc; logic [31:0] rd; logic er;
        issue(1'b1, 32'h20, 32'hDEADBEEF, 3'b010);
        n_checks++; if ({wb_we_o, wb_adr_o, wb_dat_o, wb_funct3_o} !== {1'b1, 7'h20, 32'hDEADBEEF, 3'b010}) begin n_fail++; $display("FAIL sw_bus: got %b %h %h %b expected 1 20 deadbeef 010", wb_we_o, wb_adr_o, wb_dat_o, wb_funct3_o); end
        run_to_resp(rc, cc, rd, er);
        n_checks++; if (rc !== 3 || cc !== 2 || rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL sw_resp: got cyc%0d cnt%0d %h %b expected cyc3 cnt2 00000000 0", rc, cc, rd, er); end
        @(negedge clk);
        n_checks++; if ({wb_cyc_o, req_ready} !== 2'b01) begin n_fail++; $display("FAIL sw_gap: got %b expected 01", {wb_cyc_o, req_ready}); end
        issue(1'b0, 32'h23, 32'h0, 3'b000);
        n_checks++; if ({wb_we_o, wb_adr_o, wb_funct3_o} !== {1'b0, 7'h23, 3'b000}) begin n_fail++; $display("FAIL lb_bus: got %b %h %b expected 0 23 000", wb_we_o, wb_adr_o, wb_funct3_o); end
        run_to_resp(rc, cc, rd, er);
        n_checks++; if (rc !== 3 || rd !== 32'hFFFFFFDE || er !== 1'b0) begin n_fail++; $display("FAIL lb_resp: got cyc%0d %h %b expected cyc3 ffffffde 0", rc, rd, er); end
        @(negedge clk);
        issue(1'b0, 32'h20, 32'h0, 3'b101);
        run_to_resp(rc, cc, rd, er);
        n_checks++; if (rc !== 3 || rd !== 32'h0000BEEF || er !== 1'b0) begin n_fail++; $display("FAIL lhu_resp: got cyc%0d %h %b expected cyc3 0000beef 0", rc, rd, er); end
        @(negedge clk);
    endtask

    task automatic test_errors;
        logic        we_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad_t [4] = '{32'h22, 32'h21, 32'h00, 32'h80};
        logic [2:0]  f3_t [4] = '{3'b010, 3'b001, 3'b100, 3'b010};
        int rc, cc; logic [31:0] rd; logic er;
        for (int i = 0; i < 4; i++) begin
            issue(we_t[i], ad_t[i], 32'hFFFFFFFF, f3_t[i]);
            run_to_resp(rc, cc, rd, er);
            n_checks++; if (rc !== 1 || cc !== 0 || er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_vec%0d: got cyc%0d cnt%0d %h %b expected cyc1 cnt0 00000000 1", i, rc, cc, rd, er); end
            @(negedge clk);
            n_checks++; if ({req_ready, resp_valid, wb_cyc_o} !== 3'b100) begin n_fail++; $display("FAIL err_recover%0d: got %b expected 100", i, {req_ready, resp_valid, wb_cyc_o}); end
        end
    endtask

    task automatic test_timeout;
        int rc, cc; logic [31:0] rd; logic er;
        ack_en = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 3'b010);
        run_to_resp(rc, cc, rd, er);
        n_checks++; if (rc !== 16 || cc !== 15) begin n_fail++; $display("FAIL timeout_len: got resp cyc%0d cyc_cnt %0d expected 16/15", rc, cc); end
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL timeout_resp: got %h %b expected 00000000 1", rd, er); end
        @(negedge clk);
        n_checks++; if ({req_ready, resp_valid, wb_cyc_o} !== 3'b100) begin n_fail++; $display("FAIL timeout_idle: got %b expected 100", {req_ready, resp_valid, wb_cyc_o}); end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_during_bus;
        int rc, cc; logic [31:0] rd; logic er;
        issue(1'b0, 32'h10, 32'h0, 3'b010);
        n_checks++; if (wb_cyc_o !== 1'b1) begin n_fail++; $display("FAIL rst_bus_pre: got %b expected 1", wb_cyc_o); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({wb_cyc_o, wb_stb_o, resp_valid} !== 3'b000) begin n_fail++; $display("FAIL rst_bus_drop: got %b expected 000", {wb_cyc_o, wb_stb_o, resp_valid}); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({req_ready, resp_valid} !== 2'b10) begin n_fail++; $display("FAIL rst_bus_ready: got %b expected 10", {req_ready, resp_valid}); end
        issue(1'b0, 32'h20, 32'h0, 3'b010);
        run_to_resp(rc, cc, rd, er);
        n_checks++; if (rc !== 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL rst_bus_next_lw: got cyc%0d %h %b expected cyc3 deadbeef 0", rc, rd, er); end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = ((i % 4) == 0) ? 8'h33 : 8'h00;
        rst_n = 1'b0; ack_en = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b000;
        test_reset;
        test_load_nop;
        test_store_load;
        test_errors;
        test_timeout;
        test_reset_during_bus;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
